mpu_matrix_loader: RTL and testbench

MPU_MATRIX_LOADER -- requirements
Module: mpu_matrix_loader

---
 rtl/mpu_matrix_loader.sv | 158 +++++++++++++++
 tb/tb_mpu_matrix_loader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_matrix_loader.sv
`default_nettype none
// ============================================================================
// Module   : mpu_matrix_loader
// Purpose  : Collects a row-major stream of signed 8-bit elements into a
//            packed 5x5 matrix for the determinant stage. The matrix is held
//            stable for SETTLE_CYCLES clocks before done is pulsed.
// Revision : 1.0 - initial release
// ============================================================================
module mpu_matrix_loader #(
    parameter int SETTLE_CYCLES = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic signed [7:0]  size,
    input  logic               in_valid,
    input  logic signed [7:0]  in_data,
    output logic               in_ready,
    output logic signed [0:199] matrix,
    output logic signed [7:0]  matrix_size,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_load   = 2'd1;
    localparam logic [1:0] c_st_settle = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [7:0] c_settle_init = 8'(SETTLE_CYCLES);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [2:0]         r_row;
    logic [2:0]         r_col;
    logic [7:0]         r_cnt;
    logic               r_in_ready;
    logic               r_error;
    logic [0:199]       r_matrix;
    logic signed [7:0]  r_size;

    logic               w_size_ok;
    logic               w_start_ok;
    logic               w_start_bad;
    logic               w_beat;
    logic [2:0]         w_last_idx;
    logic               w_col_end;
    logic               w_last;
    logic [4:0]         w_elem_idx;

    // Only orders 1..5 fit the 5x5 storage; anything else is rejected.
    assign w_size_ok   = (size > 8'sd0) && (size < 8'sd6);
    assign w_start_ok  = (r_state == c_st_idle) && start && w_size_ok;
    assign w_start_bad = (r_state == c_st_idle) && start && !w_size_ok;

    // in_ready is high only in LOAD, so a beat implies the LOAD state.
    assign w_beat     = in_valid && r_in_ready;
    assign w_last_idx = r_size[2:0] - 3'd1;
    assign w_col_end  = (r_col == w_last_idx);
    assign w_last     = w_beat && w_col_end && (r_row == w_last_idx);

    // Element index row*5 + col, at most 24; bit offset is index*8.
    assign w_elem_idx = {r_row, 2'b00} + {2'b00, r_row} + {2'b00, r_col};

    assign in_ready    = r_in_ready;
    assign matrix      = r_matrix;
    assign matrix_size = r_size;
    assign busy        = (r_state != c_st_idle);
    assign done        = (r_state == c_st_done);
    assign error       = r_error;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a zero settle time skips SETTLE entirely.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_start_ok) begin
                    w_next_state = c_st_load;
                end
            end
            c_st_load: begin
                if (w_last) begin
                    w_next_state = (SETTLE_CYCLES == 0) ? c_st_done : c_st_settle;
                end
            end
            c_st_settle: begin
                if (r_cnt <= 8'd1) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // in_ready is a flop so it has no combinational path from in_valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == c_st_load);
        end
    end

    // Matrix storage, latched order, row/col counters and settle counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_matrix <= '0;
            r_size   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_cnt    <= '0;
            r_error  <= 1'b0;
        end else begin
            r_error <= w_start_bad;

            if (w_start_ok) begin
                r_size   <= size;
                r_matrix <= '0;
                r_row    <= '0;
                r_col    <= '0;
            end else if (w_beat) begin
                r_matrix[{w_elem_idx, 3'b000} +: 8] <= in_data;
                if (w_last) begin
                    r_row <= '0;
                    r_col <= '0;
                end else if (w_col_end) begin
                    r_col <= '0;
                    r_row <= r_row + 3'd1;
                end else begin
                    r_col <= r_col + 3'd1;
                end
            end

            if (w_last) begin
                r_cnt <= c_settle_init;
            end else if ((r_state == c_st_settle) && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mpu_matrix_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpu_matrix_loader
// Purpose  : Directed bench for mpu_matrix_loader. Two instances (settle 7 and
//            settle 0) share stimulus; a transaction-level model predicts
//            every output each cycle, and literal checks pin key results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpu_matrix_loader;

    logic clock = 1'b0;
    logic reset, start, in_valid;
    logic signed [7:0] size, in_data;

    logic rdy0, rdy1, bsy0, bsy1, dn0, dn1, er0, er1;
    logic signed [0:199] mat0, mat1;
    logic signed [7:0] msz0, msz1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    mpu_matrix_loader #(.SETTLE_CYCLES(7)) u_dut0 (
        .clock(clock), .reset(reset), .start(start), .size(size),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
        .matrix(mat0), .matrix_size(msz0), .busy(bsy0), .done(dn0), .error(er0)
    );

    mpu_matrix_loader #(.SETTLE_CYCLES(0)) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .size(size),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
        .matrix(mat1), .matrix_size(msz1), .busy(bsy1), .done(dn1), .error(er1)
    );

    // ---------------- reference model (transaction level) ----------------
    int settle_of[2] = '{7, 0};
    int m_mat[2][25];
    int m_size[2]    = '{0, 0};
    int m_left[2]    = '{0, 0};
    int m_idx[2]     = '{0, 0};
    int m_done_at[2] = '{-1, -1};
    int m_err_at[2]  = '{-1, -1};
    int cyc = 0;
    bit m_init = 1'b0;

    task automatic model_step();
        bit busy_now;
        int r, c;
        for (int i = 0; i < 2; i++) begin
            busy_now = (m_left[i] > 0) || (cyc <= m_done_at[i]);
            if (reset) begin
                m_init = 1'b1;
                m_size[i] = 0; m_left[i] = 0; m_idx[i] = 0;
                m_done_at[i] = -1; m_err_at[i] = -1;
                for (int k = 0; k < 25; k++) m_mat[i][k] = 0;
            end else if (!busy_now && start) begin
                if (size >= 1 && size <= 5) begin
                    m_size[i] = size;
                    m_left[i] = m_size[i] * m_size[i];
                    m_idx[i]  = 0;
                    for (int k = 0; k < 25; k++) m_mat[i][k] = 0;
                end else begin
                    m_err_at[i] = cyc + 1;
                end
            end else if (m_left[i] > 0 && in_valid) begin
                r = m_idx[i] / m_size[i];
                c = m_idx[i] % m_size[i];
                m_mat[i][r*5 + c] = in_data;
                m_idx[i]++;
                m_left[i]--;
                if (m_left[i] == 0) m_done_at[i] = cyc + settle_of[i] + 1;
            end
        end
    endtask

    function automatic logic [0:199] mvec(input int i);
        logic [0:199] v;
        v = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                v[(r*40 + c*8) +: 8] = 8'(m_mat[i][r*5 + c]);
        return v;
    endfunction

    function automatic logic [7:0] elem(input logic [0:199] m, input int r, input int c);
        return m[(r*40 + c*8) +: 8];
    endfunction

    function automatic logic g_rdy(input int i);
        return (i == 0) ? rdy0 : rdy1;
    endfunction

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model advances on every rising edge using the inputs held over that cycle.
    initial begin
        forever begin
            @(posedge clock);
            model_step();
            cyc++;
        end
    end

    // Every cycle after the first reset edge, all outputs of both instances
    // are compared against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (m_init) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("dut%0d.in_ready", i), g_rdy(i), m_left[i] > 0);
                    chk($sformatf("dut%0d.busy", i), (i == 0) ? bsy0 : bsy1,
                        (m_left[i] > 0) || (cyc <= m_done_at[i]));
                    chk($sformatf("dut%0d.done", i), (i == 0) ? dn0 : dn1, cyc == m_done_at[i]);
                    chk($sformatf("dut%0d.error", i), (i == 0) ? er0 : er1, cyc == m_err_at[i]);
                    chk($sformatf("dut%0d.matrix_size", i),
                        $unsigned((i == 0) ? msz0 : msz1), 8'(m_size[i]));
                    chk($sformatf("dut%0d.matrix", i), (i == 0) ? mat0 : mat1, mvec(i));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        int n = 0;
        while ((bsy0 || bsy1) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("wait_idle.timeout", n < 100, 1'b1);
    endtask

    task automatic do_start(input int sz);
        wait_idle();
        @(negedge clock);
        start = 1'b1;
        size  = 8'(sz);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_beats(input int sel, input int n, input int vals[25], input bit drop);
        int i = 0, k = 0, g = 0;
        while (i < n && g < 400) begin
            @(negedge clock);
            in_valid = !(drop && (k % 3 == 2));
            in_data  = 8'(vals[i]);
            if (in_valid && g_rdy(sel)) i++;
            k++;
            g++;
        end
        chk("send_beats.count", i, n);
    endtask

    // Measures cycles from the last beat to done on both instances.
    task automatic wait_done(input string nm, input int exp0, input int exp1);
        int n = 0, n0 = -1, n1 = -1;
        while (n0 < 0 && n < 60) begin
            @(negedge clock);
            in_valid = 1'b0;
            n++;
            if (n == 1) chk({nm, ".ready_low"}, {rdy0, rdy1}, 2'b00);
            if (dn1 && n1 < 0) n1 = n;
            if (dn0) n0 = n;
        end
        chk({nm, ".latency0"}, n0, exp0);
        chk({nm, ".latency1"}, n1, exp1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".matrix0"}, mat0, '0);
        chk({nm, ".matrix1"}, mat1, '0);
        chk({nm, ".size"}, {msz0, msz1}, 16'h0);
        chk({nm, ".flags"}, {rdy0, rdy1, bsy0, bsy1, dn0, dn1, er0, er1}, 8'h00);
    endtask

    // Overall time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int v[25];
        int bad[3];
        logic [0:199] lit;
        logic [0:199] saved;
        int n;

        reset = 1'b1; start = 1'b0; size = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk_all_zero("reset");

        // size 2 load: 3,1,4,2
        v = '{default: 0};
        v[0] = 3; v[1] = 1; v[2] = 4; v[3] = 2;
        do_start(2);
        send_beats(0, 4, v, 1'b0);
        wait_done("t2x2", 8, 1);
        lit = '0;
        lit[0 +: 8] = 8'd3; lit[8 +: 8] = 8'd1; lit[40 +: 8] = 8'd4; lit[48 +: 8] = 8'd2;
        chk("t2x2.matrix0", mat0, lit);
        chk("t2x2.matrix1", mat1, lit);
        chk("t2x2.size", msz0, 8'd2);

        // size 5 load, values 1..25, valid dropped every third cycle
        for (int i = 0; i < 25; i++) v[i] = i + 1;
        do_start(5);
        send_beats(0, 25, v, 1'b1);
        wait_done("t5x5", 8, 1);
        chk("t5x5.e44", mat0[192 +: 8], 8'd25);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                chk($sformatf("t5x5.e%0d%0d", r, c), elem(mat1, r, c), 8'(5*r + c + 1));

        // invalid orders: 0, 6, -1
        bad[0] = 0; bad[1] = 6; bad[2] = -1;
        saved = mat0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            start = 1'b1;
            size  = 8'(bad[j]);
            @(negedge clock);
            start = 1'b0;
            chk($sformatf("err%0d.pulse", j), {er0, er1, bsy0, bsy1}, 4'b1100);
            @(negedge clock);
            chk($sformatf("err%0d.clear", j), {er0, er1, bsy0, bsy1}, 4'b0000);
        end
        chk("err.matrix_kept", mat0, saved);
        chk("err.size_kept", msz0, 8'd5);

        // size 3 of -9 then size 1 of 7: start must clear the matrix
        for (int i = 0; i < 25; i++) v[i] = -9;
        do_start(3);
        send_beats(0, 9, v, 1'b0);
        wait_done("t3x3", 8, 1);
        chk("t3x3.e22", elem(mat0, 2, 2), 8'hF7);
        v[0] = 7;
        do_start(1);
        send_beats(0, 1, v, 1'b0);
        wait_done("t1x1", 8, 1);
        lit = '0;
        lit[0 +: 8] = 8'd7;
        chk("t1x1.matrix0", mat0, lit);
        chk("t1x1.matrix1", mat1, lit);
        chk("t1x1.size", msz1, 8'd1);

        // reset after 5 of 9 beats
        for (int i = 0; i < 25; i++) v[i] = 11 + i;
        do_start(3);
        send_beats(0, 5, v, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_all_zero("midreset");
        n = 0;
        repeat (12) begin
            @(negedge clock);
            if (dn0 || dn1 || bsy0 || bsy1) n++;
        end
        chk("midreset.no_done", n, 0);
        v[0] = -128;
        do_start(1);
        send_beats(0, 1, v, 1'b0);
        wait_done("postreset", 8, 1);
        chk("postreset.e00", elem(mat0, 0, 0), 8'h80);

        // start held high through LOAD/SETTLE/DONE (settle 0 instance)
        v[0] = 10; v[1] = 20; v[2] = 30; v[3] = 40;
        wait_idle();
        @(negedge clock);
        start = 1'b1;
        size  = 8'sd2;
        send_beats(1, 4, v, 1'b0);
        n = 0;
        do begin
            @(negedge clock);
            in_valid = 1'b0;
            n++;
        end while (!dn1 && n < 20);
        chk("hold.latency1", n, 1);
        chk("hold.dut0_busy", bsy0, 1'b1);
        @(negedge clock);
        chk("hold.idle_gap", {bsy1, rdy1, dn1}, 3'b000);
        @(negedge clock);
        chk("hold.reload", {bsy1, rdy1, rdy0}, 3'b110);
        start = 1'b0;
        v[0] = 1; v[1] = 2; v[2] = 3; v[3] = 4;
        send_beats(1, 4, v, 1'b0);
        n = 0;
        do begin
            @(negedge clock);
            in_valid = 1'b0;
            n++;
        end while (!dn1 && n < 20);
        chk("hold2.latency1", n, 1);
        wait_idle();
        chk("hold.dut0_e11", elem(mat0, 1, 1), 8'd40);
        chk("hold.dut1_e00", elem(mat1, 0, 0), 8'd1);
        chk("hold.dut1_e11", elem(mat1, 1, 1), 8'd4);

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
